// File: rtl/countdown_w_autoreload.sv
// countdown_w_autoreload
//   Loadable down-counter with one-shot / periodic auto-reload.
//   A start pulse latches reload_value and periodic and enters RUN.
//   The count decrements on enabled cycles. An enabled cycle at zero is an
//   expiry: expired pulses for one cycle and expire_cnt increments,
//   saturating at 255. In periodic mode the count reloads and stays in RUN.
//   In one-shot mode the counter parks in DONE.
//   Per-edge priority: stop > start > counting.
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   en           : count enable (pauses the count when low)
//   start        : load reload_value / periodic and enter RUN
//   stop         : abort to IDLE
//   periodic     : 1 = auto-reload on expiry, 0 = one-shot (sampled at start)
//   reload_value : start/reload count (sampled at start)
//   value        : current count
//   busy         : high while in RUN
//   expired      : one-cycle pulse on each expiry
//   expire_cnt   : expiries since last start, saturating at 255
module countdown_w_autoreload #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] reload_value,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             expired,
  output logic [7:0]       expire_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_lat;
  logic             periodic_lat;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      value        <= '0;
      busy         <= 1'b0;
      expired      <= 1'b0;
      expire_cnt   <= 8'd0;
      reload_lat   <= '0;
      periodic_lat <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (stop) begin
        // Abort: expire_cnt is intentionally kept for inspection.
        state <= S_IDLE;
        value <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        // A start in RUN overrides any expiry that would fall on this edge.
        reload_lat   <= reload_value;
        periodic_lat <= periodic;
        value        <= reload_value;
        expire_cnt   <= 8'd0;
        busy         <= 1'b1;
        state        <= S_RUN;
      end else if (state == S_RUN && en) begin
        if (value != '0) begin
          value <= value - 1'b1;
        end else begin
          expired    <= 1'b1;
          expire_cnt <= sat_inc8(expire_cnt);
          if (periodic_lat) begin
            value <= reload_lat;
          end else begin
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_w_autoreload.sv
module tb_countdown_w_autoreload;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] reload_value;
  logic [7:0] value;
  logic       busy;
  logic       expired;
  logic [7:0] expire_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_w_autoreload #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (start),
    .stop         (stop),
    .periodic     (periodic),
    .reload_value (reload_value),
    .value        (value),
    .busy         (busy),
    .expired      (expired),
    .expire_cnt   (expire_cnt)
  );

  // Reference model state (0 idle, 1 run, 2 done)
  int         m_state;
  logic [7:0] m_val;
  logic       m_busy;
  logic       m_exp;
  logic [7:0] m_cnt;
  logic [7:0] m_rl;
  logic       m_per;

  typedef struct {
    logic [7:0] v;
    logic       b;
    logic       e;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_val = 0; m_busy = 0; m_exp = 0; m_cnt = 0; m_rl = 0; m_per = 0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input logic s, input logic st, input logic e,
                      input logic p, input logic [7:0] rv);
    exp_t x;
    @(negedge clk);
    start = s; stop = st; en = e; periodic = p; reload_value = rv;
    m_exp = 1'b0;
    if (st) begin
      m_state = 0; m_val = 0; m_busy = 0;
    end else if (s) begin
      m_rl = rv; m_per = p; m_val = rv; m_cnt = 0; m_busy = 1; m_state = 1;
    end else if (m_state == 1 && e) begin
      if (m_val != 0) m_val = m_val - 8'd1;
      else begin
        m_exp = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        if (m_per) m_val = m_rl;
        else begin m_busy = 0; m_state = 2; end
      end
    end
    x.v = m_val; x.b = m_busy; x.e = m_exp; x.c = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("sb_value", value, x.v);
      chk("sb_busy", busy, x.b);
      chk("sb_expired", expired, x.e);
      chk("sb_expire_cnt", expire_cnt, x.c);
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 0; start = 0; stop = 0; periodic = 0; reload_value = 8'hA5;
    model_reset();
    #2;
    chk("rst_value", value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_expired", expired, 0);
    chk("rst_cnt", expire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE holds with en high and no start
    step(0, 0, 1, 0, 8'd9);
    chk("idle_hold", value, 0);

    // One-shot N=3
    step(1, 0, 1, 0, 8'd3);
    chk("os_v0", value, 3);
    chk("os_busy0", busy, 1);
    step(0, 0, 1, 1, 8'd50);  // periodic/reload changes must be ignored
    chk("os_v1", value, 2);
    step(0, 0, 1, 0, 8'd3);
    chk("os_v2", value, 1);
    step(0, 0, 1, 0, 8'd3);
    chk("os_v3", value, 0);
    chk("os_noexp3", expired, 0);
    step(0, 0, 1, 0, 8'd3);
    chk("os_exp4", expired, 1);
    chk("os_busy4", busy, 0);
    chk("os_cnt4", expire_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 8'd3);
      chk("os_done_val", value, 0);
      chk("os_done_exp", expired, 0);
    end

    // Periodic N=2, 12 enabled cycles
    step(1, 0, 1, 1, 8'd2);
    pulses = 0;
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, 1, 0, 8'd7);
      chk("per_exp", expired, (j % 3 == 0) ? 1 : 0);
      chk("per_val", value, (j % 3 == 0) ? 2 : 2 - (j % 3));
      if (expired) pulses++;
    end
    chk("per_pulses", pulses, 4);
    chk("per_cnt", expire_cnt, 4);

    // Pause: N=4, en low for three edges while value=2
    step(1, 0, 1, 0, 8'd4);
    step(0, 0, 1, 0, 8'd4);
    step(0, 0, 1, 0, 8'd4);
    chk("pause_v2", value, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 8'd4);
      chk("pause_frozen", value, 2);
      chk("pause_noexp", expired, 0);
    end
    step(0, 0, 1, 0, 8'd4);
    step(0, 0, 1, 0, 8'd4);
    chk("pause_v0", value, 0);
    chk("pause_noexp7", expired, 0);
    step(0, 0, 1, 0, 8'd4);
    chk("pause_exp8", expired, 1);

    // Retrigger at value 0 suppresses the due expiry
    step(1, 0, 1, 0, 8'd5);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'd5);
    chk("rt_v0", value, 0);
    step(1, 0, 1, 0, 8'd7);
    chk("rt_val", value, 7);
    chk("rt_noexp", expired, 0);
    chk("rt_cnt", expire_cnt, 0);
    step(0, 0, 1, 0, 8'd7);
    step(1, 1, 1, 0, 8'd7);  // stop wins over start
    chk("stop_val", value, 0);
    chk("stop_busy", busy, 0);
    step(0, 0, 1, 0, 8'd7);
    chk("stop_idle", value, 0);

    // Periodic N=0: expiry every enabled cycle, count saturates
    step(1, 0, 1, 1, 8'd0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 0, 8'd0);
      if (expired) pulses++;
    end
    chk("zero_pulses", pulses, 300);
    chk("zero_sat", expire_cnt, 255);

    // Async reset between edges
    step(1, 0, 1, 1, 8'd9);
    step(0, 0, 1, 0, 8'd9);
    step(0, 0, 1, 0, 8'd9);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_value", value, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", expire_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // Latched reload/mode were cleared: plain start still behaves normally
    step(1, 0, 1, 0, 8'd1);
    chk("post_rst_val", value, 1);
    step(0, 0, 1, 0, 8'd1);
    step(0, 0, 1, 0, 8'd1);
    chk("post_rst_exp", expired, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
